ikaopll_write_sequencer: RTL and testbench
==========================================

// Module: ikaopll_write_sequencer
// PURPOSE
//  Host-side bus controller for IKAOPLL: queues (register, data) write requests and replays each on the
//  chip's CS_n/WR_n/A0/D bus as an address write (A0=0) then a data write (A0=1), honouring the OPLL
//  post-write wait times. Sits between a CPU/sound-driver core and IKAOPLL; runs on the same EMUCLK/phiM enable.
// PARAMETERS
//  FIFO_DEPTH   4   request queue entries; power of 2, >=2
//  WR_PULSE     2   phiM ticks WR_n held low per strobe; >=1
//  ADDR_WAIT    12  phiM ticks of bus idle after address write; >=1
//  DATA_WAIT    84  phiM ticks of bus idle after data write; >=1
// PORTS
//  i_EMUCLK       in   1  emulator clock; all state on posedge
//  i_IC_n         in   1  async active-low reset
//  i_phiM_PCEN_n  in   1  active-low phiM tick enable; sequencer advances only when 0
//  i_REQ_VALID    in   1  request valid
//  o_REQ_READY    out  1  request accepted when VALID&READY on a posedge (any cycle, not tick-gated)
//  i_REQ_ADDR     in   8  OPLL register number
//  i_REQ_DATA     in   8  register data
//  o_CS_n/o_WR_n  out  1  to IKAOPLL i_CS_n/i_WR_n
//  o_A0           out  1  to IKAOPLL i_A0
//  o_D            out  8  to IKAOPLL i_D
//  o_D_OE         out  1  high while o_D is driven
//  o_BUSY         out  1  FIFO non-empty or FSM not IDLE
//  o_DONE         out  1  one-EMUCLK pulse on the tick a data wait completes
// BEHAVIOUR
//  Reset (i_IC_n=0, async): FIFO flushed, FSM=IDLE, CS_n=1, WR_n=1, A0=0, D=8'h00, D_OE=0, BUSY=0, DONE=0,
//   REQ_READY=1 (=!full). Reset mid-transfer aborts immediately; bus released same instant.
//  FIFO: push on VALID&READY; READY=!full; pop only in IDLE on a tick with FIFO non-empty. Push and pop
//   in the same cycle both take effect; count unchanged. No push when full (READY=0).
//  FSM (advances on ticks only; counter loaded on entry, state exits when counter hits 0):
//   IDLE     : bus idle; on tick & !empty pop head into working reg -> A_SETUP.
//   A_SETUP  1 tick : CS_n=0 WR_n=1 A0=0 D=addr D_OE=1.
//   A_STROBE WR_PULSE ticks : as A_SETUP with WR_n=0.
//   A_HOLD   1 tick : CS_n=1 WR_n=1, D/A0 held, D_OE=1.
//   A_WAIT   ADDR_WAIT ticks : CS_n=1 WR_n=1 D_OE=0 -> D_SETUP.
//   D_SETUP/D_STROBE/D_HOLD : same timing, A0=1, D=data.
//   D_WAIT   DATA_WAIT ticks : bus idle; on exit pulse DONE -> IDLE.
//  Per write = 2*(WR_PULSE+2)+ADDR_WAIT+DATA_WAIT ticks (defaults: 104 ticks). Back-to-back queued writes:
//   next A_SETUP on the tick after D_WAIT exit (IDLE lasts exactly 1 tick).
//  Outputs registered; change only on tick posedges. CS_n and WR_n never both low outside *_STROBE.
//  Counter width $clog2(max(WR_PULSE,ADDR_WAIT,DATA_WAIT)+1).
// CONFIGURATION
//  IKAOPLL_SEQ_ADDR_SKIP_EN defined: sequencer keeps last-written address (valid flag cleared on reset);
//   if popped addr equals it, IDLE -> D_SETUP directly (address phase and ADDR_WAIT skipped).
//  Not defined: every request performs full address + data phases.
// STRUCTURE
//  Package ikaopll_seq_pkg: state enum (IDLE,A_SETUP,A_STROBE,A_HOLD,A_WAIT,D_SETUP,D_STROBE,D_HOLD,
//   D_WAIT), request struct {addr[7:0],data[7:0]}.
//  Sub-module ikaopll_seq_fifo: FIFO_DEPTH x 16-bit sync FIFO, async-reset pointers, full/empty.
// TESTING (phiM tick = every 4th EMUCLK)
//  1 Reset: hold i_IC_n=0 with VALID=1 -> CS_n=1,WR_n=1,D_OE=0,BUSY=0, nothing queued after release.
//  2 Single write 0x10/0x7A -> A0=0,D=0x10,WR_n low 2 ticks; 12 idle ticks; A0=1,D=0x7A,WR_n low 2 ticks;
//    DONE 104 ticks after pop; BUSY falls same tick.
//  3 Push 5 requests back-to-back with FIFO_DEPTH=4 -> READY low after 4th (1 popped, so 5th accepted
//    after first pop); all 5 replayed in order, 104 ticks each, DONE x5.
//  4 Assert i_IC_n=0 during D_STROBE -> CS_n/WR_n go 1 asynchronously; FIFO empty after release.
//  5 Hold i_phiM_PCEN_n=1 for 50 EMUCLK mid-A_WAIT -> no output or state change; wait resumes after.
//  6 With IKAOPLL_SEQ_ADDR_SKIP_EN: writes 0x20/0x01 then 0x20/0x02 -> second has no A0=0 strobe,
//    completes in 88 ticks; write 0x21 next -> full 104-tick sequence.

Source files
------------

// File: rtl/ikaopll_seq_pkg.sv
// Shared types for the IKAOPLL write sequencer: FSM state encoding, the queued
// request record, and a small helper used to size the phase counter.
package ikaopll_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    A_WAIT,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    D_WAIT
  } seq_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } seq_req_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/ikaopll_seq_fifo.sv
// Request queue for the write sequencer: DEPTH entries of one (register, data)
// pair each. Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter. Storage is not reset; flushing the
// pointers is enough to empty the queue.
module ikaopll_seq_fifo
  import ikaopll_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  seq_req_t data_i,
  input  logic     pop_i,
  output seq_req_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wrPtr_q, wrPtr_d;
  logic [AW:0] rdPtr_q, rdPtr_d;
  seq_req_t    mem_q [DEPTH];

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign data_o  = mem_q[rdPtr_q[AW-1:0]];

  // Advance each pointer independently so a simultaneous push and pop both land
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push_i && !full_o) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (pop_i && !empty_o) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
  end

  // Pointer registers; reset empties the queue immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Entry storage, written at the slot the write pointer currently names
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/ikaopll_write_sequencer.sv
// Host-side write sequencer for IKAOPLL. Accepts (register, data) requests from
// a CPU/driver core, queues them, and replays each one on the chip bus as an
// address write (A0=0) followed by a data write (A0=1), leaving the bus idle for
// the chip's post-write wait after each half. The FSM only moves on phiM ticks;
// the request port accepts on any EMUCLK edge.
// Optional feature: define IKAOPLL_SEQ_ADDR_SKIP_EN to skip the address phase
// (and its wait) when a request targets the register written last.
module ikaopll_write_sequencer
  import ikaopll_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_PULSE   = 2,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic       i_EMUCLK,
  input  logic       i_IC_n,
  input  logic       i_phiM_PCEN_n,
  input  logic       i_REQ_VALID,
  output logic       o_REQ_READY,
  input  logic [7:0] i_REQ_ADDR,
  input  logic [7:0] i_REQ_DATA,
  output logic       o_CS_n,
  output logic       o_WR_n,
  output logic       o_A0,
  output logic [7:0] o_D,
  output logic       o_D_OE,
  output logic       o_BUSY,
  output logic       o_DONE
);

  localparam int CNT_MAX = maxOf3(WR_PULSE, ADDR_WAIT, DATA_WAIT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] AWAIT_LOAD  = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] DWAIT_LOAD  = CNT_W'(DATA_WAIT - 1);

  logic       tick;
  seq_req_t   reqIn;
  seq_req_t   fifoHead;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       fifoPush;
  logic       fifoPop;
  logic       skipAddr;

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       workData_q;
  logic             csN_q;
  logic             wrN_q;
  logic             a0_q;
  logic [7:0]       d_q;
  logic             dOe_q;
  logic             done_q;

  assign tick       = ~i_phiM_PCEN_n;
  assign reqIn.addr = i_REQ_ADDR;
  assign reqIn.data = i_REQ_DATA;
  assign fifoPush   = i_REQ_VALID & ~fifoFull;
  assign fifoPop    = tick & (state_q == IDLE) & ~fifoEmpty;

  ikaopll_seq_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_EMUCLK),
    .rst_ni  (i_IC_n),
    .push_i  (fifoPush),
    .data_i  (reqIn),
    .pop_i   (fifoPop),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

`ifdef IKAOPLL_SEQ_ADDR_SKIP_EN
  logic [7:0] lastAddr_q;
  logic       lastAddrValid_q;

  assign skipAddr = lastAddrValid_q && (lastAddr_q == fifoHead.addr);

  // Track the register the chip currently has latched; forgotten on reset
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      lastAddr_q      <= '0;
      lastAddrValid_q <= 1'b0;
    end else if (fifoPop) begin
      lastAddr_q      <= fifoHead.addr;
      lastAddrValid_q <= 1'b1;
    end
  end
`else
  assign skipAddr = 1'b0;
`endif

  // Bus sequencer: each state holds for its tick budget, then loads the next
  // state's budget together with that state's bus levels, so the outputs are
  // registered and only move on tick edges
  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      workData_q <= '0;
      csN_q      <= 1'b1;
      wrN_q      <= 1'b1;
      a0_q       <= 1'b0;
      d_q        <= 8'h00;
      dOe_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tick) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_ONE;
        end else begin
          case (state_q)
            IDLE: begin
              if (!fifoEmpty) begin
                workData_q <= fifoHead.data;
                cnt_q      <= '0;
                csN_q      <= 1'b0;
                wrN_q      <= 1'b1;
                dOe_q      <= 1'b1;
                if (skipAddr) begin
                  state_q <= D_SETUP;
                  a0_q    <= 1'b1;
                  d_q     <= fifoHead.data;
                end else begin
                  state_q <= A_SETUP;
                  a0_q    <= 1'b0;
                  d_q     <= fifoHead.addr;
                end
              end
            end
            A_SETUP: begin
              state_q <= A_STROBE;
              cnt_q   <= STROBE_LOAD;
              wrN_q   <= 1'b0;
            end
            A_STROBE: begin
              state_q <= A_HOLD;
              cnt_q   <= '0;
              wrN_q   <= 1'b1;
              csN_q   <= 1'b1;
            end
            A_HOLD: begin
              state_q <= A_WAIT;
              cnt_q   <= AWAIT_LOAD;
              dOe_q   <= 1'b0;
            end
            A_WAIT: begin
              state_q <= D_SETUP;
              cnt_q   <= '0;
              csN_q   <= 1'b0;
              a0_q    <= 1'b1;
              d_q     <= workData_q;
              dOe_q   <= 1'b1;
            end
            D_SETUP: begin
              state_q <= D_STROBE;
              cnt_q   <= STROBE_LOAD;
              wrN_q   <= 1'b0;
            end
            D_STROBE: begin
              state_q <= D_HOLD;
              cnt_q   <= '0;
              wrN_q   <= 1'b1;
              csN_q   <= 1'b1;
            end
            D_HOLD: begin
              state_q <= D_WAIT;
              cnt_q   <= DWAIT_LOAD;
              dOe_q   <= 1'b0;
            end
            D_WAIT: begin
              state_q <= IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= '0;
              csN_q   <= 1'b1;
              wrN_q   <= 1'b1;
              dOe_q   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign o_REQ_READY = ~fifoFull;
  assign o_CS_n      = csN_q;
  assign o_WR_n      = wrN_q;
  assign o_A0        = a0_q;
  assign o_D         = d_q;
  assign o_D_OE      = dOe_q;
  assign o_DONE      = done_q;
  assign o_BUSY      = ~fifoEmpty | (state_q != IDLE);

endmodule

// File: tb/tb_ikaopll_write_sequencer.sv
// Self-checking bench for ikaopll_write_sequencer. A behavioural model tracks the
// request queue and, for the write in flight, the number of ticks since it was
// popped; expected bus levels follow from where that offset falls in the write
// timeline. A compare process checks the DUT against the model on every EMUCLK
// falling edge, and the directed scenarios add literal timing expectations.
module tb_ikaopll_write_sequencer;

  localparam int DEPTH    = 4;
  localparam int WRP      = 2;
  localparam int AWT      = 12;
  localparam int DWT      = 84;
  localparam int FULL_LEN = 2 * (WRP + 2) + AWT + DWT;
  localparam int DATA_OFS = WRP + 2 + AWT;

`ifdef IKAOPLL_SEQ_ADDR_SKIP_EN
  localparam bit SKIP_EN        = 1'b1;
  localparam int REPEAT_SPAN    = 88;
  localparam int REPEAT_ASTROBE = 0;
`else
  localparam bit SKIP_EN        = 1'b0;
  localparam int REPEAT_SPAN    = 104;
  localparam int REPEAT_ASTROBE = 8;
`endif

  logic       clock = 1'b0;
  logic       icN;
  logic       pcenN = 1'b1;
  logic       reqValid = 1'b0;
  logic [7:0] reqAddr = 8'h00;
  logic [7:0] reqData = 8'h00;
  logic       reqReady;
  logic       csN;
  logic       wrN;
  logic       a0;
  logic [7:0] dBus;
  logic       dOe;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  ikaopll_write_sequencer dut (
    .i_EMUCLK      (clock),
    .i_IC_n        (icN),
    .i_phiM_PCEN_n (pcenN),
    .i_REQ_VALID   (reqValid),
    .o_REQ_READY   (reqReady),
    .i_REQ_ADDR    (reqAddr),
    .i_REQ_DATA    (reqData),
    .o_CS_n        (csN),
    .o_WR_n        (wrN),
    .o_A0          (a0),
    .o_D           (dBus),
    .o_D_OE        (dOe),
    .o_BUSY        (busy),
    .o_DONE        (done)
  );

  always #5 clock = ~clock;

  // Tick generator: every 4th EMUCLK normally, random when asked, frozen on stall
  int phase = 0;
  bit stallReq = 1'b0;
  bit randTick = 1'b0;
  always @(negedge clock) begin
    phase = (phase + 1) % 4;
    if (stallReq) pcenN = 1'b1;
    else if (randTick) pcenN = ($urandom_range(0, 2) != 0);
    else pcenN = (phase != 0);
  end

  // Running count of phiM ticks seen by the DUT
  int tickCount = 0;
  always @(posedge clock) begin
    if (!pcenN) tickCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: queue of pending requests plus offset of the active write
  bit [15:0] mQ[$];
  bit        mActive = 1'b0;
  bit        mSkip = 1'b0;
  bit        mDone = 1'b0;
  bit        mLastValid = 1'b0;
  bit [7:0]  mLastAddr = 8'h00;
  bit [7:0]  mCurA = 8'h00;
  bit [7:0]  mCurD = 8'h00;
  int        mK = 0;
  bit        mAccept;

  always @(posedge clock or negedge icN) begin
    if (!icN) begin
      mQ.delete();
      mActive = 1'b0;
      mSkip = 1'b0;
      mDone = 1'b0;
      mLastValid = 1'b0;
      mK = 0;
    end else begin
      mAccept = reqValid && (mQ.size() < DEPTH);
      mDone = 1'b0;
      if (!pcenN) begin
        if (mActive) begin
          mK++;
          if (mK == (mSkip ? FULL_LEN - DATA_OFS : FULL_LEN)) begin
            mActive = 1'b0;
            mDone = 1'b1;
          end
        end else if (mQ.size() > 0) begin
          {mCurA, mCurD} = mQ.pop_front();
          mSkip = SKIP_EN && mLastValid && (mCurA == mLastAddr);
          mLastValid = 1'b1;
          mLastAddr = mCurA;
          mK = 0;
          mActive = 1'b1;
        end
      end
      if (mAccept) mQ.push_back({reqAddr, reqData});
    end
  end

  // Compare DUT outputs with the model on every falling edge
  always @(negedge clock) begin : compare
    int   o;
    logic eCs, eWr, eOe, eA0;
    logic [7:0] eD;
    eCs = 1'b1; eWr = 1'b1; eOe = 1'b0; eA0 = 1'b0; eD = 8'h00;
    if (mActive) begin
      o = mSkip ? mK + DATA_OFS : mK;
      if (o >= DATA_OFS) begin
        eA0 = 1'b1;
        eD = mCurD;
        o = o - DATA_OFS;
      end else begin
        eD = mCurA;
      end
      if (o <= WRP + 1) begin
        eOe = 1'b1;
        eCs = (o > WRP);
        eWr = !(o >= 1 && o <= WRP);
      end
    end
    checkOutput("CS_n", 32'(csN), 32'(eCs));
    checkOutput("WR_n", 32'(wrN), 32'(eWr));
    checkOutput("D_OE", 32'(dOe), 32'(eOe));
    if (eOe) begin
      checkOutput("A0", 32'(a0), 32'(eA0));
      checkOutput("D", 32'(dBus), 32'(eD));
    end
    checkOutput("DONE", 32'(done), 32'(mDone));
    checkOutput("BUSY", 32'(busy), 32'(mActive || (mQ.size() > 0)));
    checkOutput("REQ_READY", 32'(reqReady), 32'(mQ.size() < DEPTH));
  end

  // Per-write measurements in ticks and EMUCLKs for the literal expectations
  bit       inTx = 1'b0;
  logic     prevCs = 1'b1;
  logic     prevOe = 1'b0;
  int       txStart = 0, txSpan = 0, oeFall = 0, oeGap = 0;
  int       aStrobeClk = 0, dStrobeClk = 0, doneCount = 0;
  logic [7:0] seenAddr = 8'h00, seenData = 8'h00;
  always @(negedge clock) begin
    if (!icN) begin
      inTx = 1'b0;
    end else begin
      if (prevCs && !csN && !inTx) begin
        inTx = 1'b1;
        txStart = tickCount;
        aStrobeClk = 0;
        dStrobeClk = 0;
        oeGap = 0;
      end
      if (inTx && !wrN) begin
        if (a0) begin dStrobeClk++; seenData = dBus; end
        else begin aStrobeClk++; seenAddr = dBus; end
      end
      if (inTx && prevOe && !dOe) oeFall = tickCount;
      if (inTx && !prevOe && dOe) oeGap = tickCount - oeFall;
      if (inTx && done) begin
        txSpan = tickCount - txStart;
        inTx = 1'b0;
        doneCount++;
      end
    end
    prevCs = csN;
    prevOe = dOe;
  end

  // Offer one request and return once it has been accepted (stalls = clocks refused)
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, output int stalls);
    stalls = 0;
    @(negedge clock);
    reqValid = 1'b1;
    reqAddr = a;
    reqData = d;
    while (!reqReady && stalls < 5000) begin
      stalls++;
      @(negedge clock);
    end
    checkOutput("push-timeout", 32'(reqReady), 32'd1);
    @(posedge clock);
    #1 reqValid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    @(negedge clock);
    while (busy && n < limit) begin
      n++;
      @(negedge clock);
    end
    checkOutput("idle-timeout", 32'(busy), 32'd0);
    @(negedge clock);
  endtask

  task automatic waitStrobe(input logic wantA0, input int limit);
    int n = 0;
    @(negedge clock);
    while (!(!wrN && a0 == wantA0) && n < limit) begin
      n++;
      @(negedge clock);
    end
    checkOutput("strobe-timeout", 32'(n >= limit), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clock);
    #1 icN = 1'b0;
    repeat (3) @(negedge clock);
    #1 icN = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int stalls, total, doneBase, n;

    // Reset with a request offered: nothing may be queued
    icN = 1'b0;
    reqValid = 1'b1;
    reqAddr = 8'($urandom);
    reqData = 8'($urandom);
    repeat (6) @(negedge clock);
    checkOutput("rst-CS_n", 32'(csN), 32'd1);
    checkOutput("rst-WR_n", 32'(wrN), 32'd1);
    checkOutput("rst-D_OE", 32'(dOe), 32'd0);
    checkOutput("rst-BUSY", 32'(busy), 32'd0);
    checkOutput("rst-A0", 32'(a0), 32'd0);
    checkOutput("rst-D", 32'(dBus), 32'h00);
    checkOutput("rst-DONE", 32'(done), 32'd0);
    checkOutput("rst-READY", 32'(reqReady), 32'd1);
    reqValid = 1'b0;
    #1 icN = 1'b1;
    repeat (8) @(negedge clock);
    checkOutput("post-rst-BUSY", 32'(busy), 32'd0);
    checkOutput("post-rst-CS_n", 32'(csN), 32'd1);

    // Single write timing
    $display("[TB] single write 0x10/0x7A");
    applyStimulus(8'h10, 8'h7A, stalls);
    waitIdle(3000);
    checkOutput("single-span", 32'(txSpan), 32'd104);
    checkOutput("single-addr-strobe", 32'(aStrobeClk), 32'd8);
    checkOutput("single-data-strobe", 32'(dStrobeClk), 32'd8);
    checkOutput("single-addr", 32'(seenAddr), 32'h10);
    checkOutput("single-data", 32'(seenData), 32'h7A);
    checkOutput("single-addr-wait", 32'(oeGap), 32'd12);

    // Five back-to-back requests, first accepted on a tick edge
    $display("[TB] five queued writes");
    n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (pcenN && n < 100);
    repeat (3) @(posedge clock);
    doneBase = doneCount;
    total = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(8'h60 + i), 8'($urandom), stalls);
      total += stalls;
    end
    checkOutput("queue-stalls", 32'(total), 32'd1);
    waitIdle(5000);
    checkOutput("queue-done-count", 32'(doneCount - doneBase), 32'd5);
    checkOutput("queue-last-span", 32'(txSpan), 32'd104);
    checkOutput("queue-last-addr", 32'(seenAddr), 32'h64);

    // Reset during the data strobe releases the bus at once and flushes the queue
    $display("[TB] reset during data strobe");
    applyStimulus(8'h50, 8'h11, stalls);
    applyStimulus(8'h51, 8'h22, stalls);
    waitStrobe(1'b1, 2000);
    #2 icN = 1'b0;
    #1;
    checkOutput("abort-CS_n", 32'(csN), 32'd1);
    checkOutput("abort-WR_n", 32'(wrN), 32'd1);
    checkOutput("abort-D_OE", 32'(dOe), 32'd0);
    @(negedge clock);
    checkOutput("abort-BUSY", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    #1 icN = 1'b1;
    repeat (12) @(negedge clock);
    checkOutput("abort-post-BUSY", 32'(busy), 32'd0);

    // Tick enable frozen for 50 EMUCLK in the middle of the address wait
    $display("[TB] tick stall during address wait");
    applyStimulus(8'h40, 8'h55, stalls);
    waitStrobe(1'b0, 2000);
    n = 0;
    while (dOe && n < 2000) begin
      n++;
      @(negedge clock);
    end
    repeat (8) @(negedge clock);
    stallReq = 1'b1;
    repeat (50) @(negedge clock);
    stallReq = 1'b0;
    waitIdle(3000);
    checkOutput("stall-span", 32'(txSpan), 32'd104);
    checkOutput("stall-addr-wait", 32'(oeGap), 32'd12);

    // Randomized requests with random tick spacing
    $display("[TB] randomized traffic");
    randTick = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clock);
      applyStimulus(8'(8'h30 + $urandom_range(0, 1)), 8'($urandom), stalls);
    end
    waitIdle(20000);
    randTick = 1'b0;

    // Repeated register address
    $display("[TB] repeated register address");
    doReset();
    applyStimulus(8'h20, 8'h01, stalls);
    waitIdle(3000);
    checkOutput("repeat-first-span", 32'(txSpan), 32'd104);
    applyStimulus(8'h20, 8'h02, stalls);
    waitIdle(3000);
    checkOutput("repeat-second-span", 32'(txSpan), 32'(REPEAT_SPAN));
    checkOutput("repeat-second-addr-strobe", 32'(aStrobeClk), 32'(REPEAT_ASTROBE));
    checkOutput("repeat-second-data", 32'(seenData), 32'h02);
    applyStimulus(8'h21, 8'h03, stalls);
    waitIdle(3000);
    checkOutput("repeat-new-span", 32'(txSpan), 32'd104);
    checkOutput("repeat-new-addr-strobe", 32'(aStrobeClk), 32'd8);
    checkOutput("repeat-new-addr", 32'(seenAddr), 32'h21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
